rel_fifo_push_arbiter: RTL and testbench
========================================

// Module: rel_fifo_push_arbiter
//
// PURPOSE
// - Shares the push side of one rel_fifo among NumReq requesters with a TMR-protected round-robin arbiter.
// - Supervises the FIFO fault output and sequences flush/recovery: persistent faults flush the FIFO.
// - Sits directly in front of rel_fifo.
// - Parameters DataWidth and TmrStatus match the FIFO instance; HsWidth is derived from TmrStatus.
//
// PARAMETERS
// - NumReq       default 4   number of requesters, >=1
// - DataWidth    default 39  payload width (ECC-encoded upstream)
// - TmrStatus    default 0   1: FIFO handshake/status signals are triplicated (HsWidth=3)
// - FaultThresh  default 4   consecutive fifo_fault_i cycles that trigger a flush, >=1
// - HoldCycles   default 2   cycles pushes stay blocked after a flush, >=1
// - IdxWidth     derived     cf_math_pkg::idx_width(NumReq); do not override
// - HsWidth      derived     TmrStatus ? 3 : 1; do not override
//
// PORTS
// - clk_i          in   1                 clock
// - rst_ni         in   1                 asynchronous reset, active low
// - req_valid_i    in   NumReq            requester has data
// - req_data_i     in   NumReq*DataWidth  requester payloads
// - req_ready_o    out  NumReq            payload accepted this cycle
// - flush_req_i    in   1                 software flush request
// - fault_clear_i  in   1                 clears sticky fault (macro only)
// - fifo_full_i    in   HsWidth           rel_fifo full_o
// - fifo_fault_i   in   1                 rel_fifo fault_o
// - fifo_push_o    out  HsWidth           to rel_fifo push_i, all copies equal
// - fifo_data_o    out  DataWidth         to rel_fifo data_i
// - fifo_flush_o   out  HsWidth           to rel_fifo flush_i, all copies equal
// - busy_o         out  1                 FSM not in RUN
// - fault_o        out  1                 voter mismatch in this block, or sticky fault
//
// BEHAVIOUR
// Reset values:
// - req_ready_o, fifo_push_o and fifo_flush_o are 0.
// - busy_o is 0 and fault_o is 0.
// - All three copies of the round-robin pointer are 0; the fault counter is 0; the FSM is in RUN.
//
// Input voting:
// - If TmrStatus=1, fifo_full_i is majority-voted.
// - Any disagreement among the copies sets fault_o for that cycle.
//
// Arbitration (combinational, zero latency):
// - gnt is the first index i with req_valid_i[i], scanning from ptr upward and wrapping at NumReq-1 -> 0.
// - Accept occurs when the FSM is in RUN, any req_valid_i is high, and full is low.
// - On accept: fifo_push_o is all ones, fifo_data_o = req_data_i[gnt], and req_ready_o = onehot(gnt).
// - Otherwise req_ready_o=0 and fifo_push_o=0. fifo_data_o is don't-care but still driven as the mux of gnt.
// - ready never depends on a valid from another cycle. A requester may drop valid without being accepted.
//
// Pointer:
// - The pointer is held as 3 copies, majority-voted every cycle, and the voted value is written back into all copies.
// - On accept, next ptr = gnt+1, or 0 if gnt == NumReq-1. Without an accept, ptr holds.
// - A copy mismatch sets fault_o for that cycle and self-corrects on the next edge.
// - If NumReq==1, ptr is constant 0 and no pointer state is instantiated.
//
// FSM states RUN, FLUSH, HOLD:
// - RUN -> FLUSH when flush_req_i is high, or when fault_cnt reaches FaultThresh.
//   - fault_cnt increments on each cycle with fifo_fault_i high and saturates at FaultThresh.
//   - fault_cnt clears on any cycle with fifo_fault_i low.
// - FLUSH (exactly 1 cycle):
//   - fifo_flush_o is all ones, no accept, ptr is reset to 0, fault_cnt is cleared.
//   - Goes to HOLD with hold_cnt = HoldCycles-1.
// - HOLD: no accept. Goes to RUN when hold_cnt==0, otherwise hold_cnt decrements.
//   - flush_req_i arriving in HOLD restarts at FLUSH.
// - FLUSH has priority over an accept in the same cycle. A push is never issued in the cycle a flush is issued.
// - busy_o = (state != RUN).
// - The FSM state is also triplicated and voted; a mismatch sets fault_o.
//
// Reset mid-operation:
// - Reset returns immediately to reset values. Any in-flight flush is abandoned; the FIFO has its own reset.
//
// CONFIGURATION
// Macro REL_FIFO_ARB_STICKY_FAULT_EN:
// - Defined:
//   - fault_o is set by any internal mismatch or by a FLUSH entry caused by FaultThresh.
//   - It stays set until fault_clear_i is sampled high.
//   - Set has priority over clear in the same cycle.
// - Undefined:
//   - fault_o is combinational and per-cycle: internal voter mismatch only.
//   - fault_clear_i is ignored.
//
// TESTING
// - Round-robin: NumReq=4, all valid, full=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3, with one push per cycle.
// - Skip and wrap: ptr=2, valid=4'b0011 -> gnt=0, next ptr=1; then valid=4'b0010 -> gnt=1.
// - Backpressure: full=1 while valids are high -> push=0 and ready=0, ptr holds; full drops -> the same gnt is accepted.
// - Fault flush: FaultThresh=4, fifo_fault_i high 4 cycles
//   -> flush pulse on cycle 5 for 1 cycle, then no push for HoldCycles=2 cycles, then RUN with gnt from ptr 0.
//   - A 3-cycle fault burst -> no flush.
// - TMR: force one ptr copy to 3 for 1 cycle -> grant unchanged, fault_o=1 for 1 cycle, copies equal next cycle.
//   - With REL_FIFO_ARB_STICKY_FAULT_EN, fault_o stays 1 until fault_clear_i.
// - Reset during HOLD: assert rst_ni=0 -> busy_o=0, flush=0, push=0; after release, RUN with ptr 0.

Source files
------------

// File: rtl/rel_fifo_push_arbiter.sv
// Push-side arbiter for rel_fifo: TMR round-robin grant, fault supervision and flush/hold sequencing.
// Optional sticky fault reporting is enabled with REL_FIFO_ARB_STICKY_FAULT_EN.
module rel_fifo_push_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned DataWidth   = 39,
  parameter int unsigned TmrStatus   = 0,
  parameter int unsigned FaultThresh = 4,
  parameter int unsigned HoldCycles  = 2,
  parameter int unsigned IdxWidth    = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int unsigned HsWidth     = (TmrStatus != 0) ? 3 : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic                          flush_req_i,
  input  logic                          fault_clear_i,
  input  logic [HsWidth-1:0]            fifo_full_i,
  input  logic                          fifo_fault_i,
  output logic [HsWidth-1:0]            fifo_push_o,
  output logic [DataWidth-1:0]          fifo_data_o,
  output logic [HsWidth-1:0]            fifo_flush_o,
  output logic                          busy_o,
  output logic                          fault_o
);

  localparam int unsigned CntWidth  = $clog2(FaultThresh + 1);
  localparam int unsigned HoldWidth = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StHold  = 2'd2
  } state_e;

  logic                 fullVoted;
  logic                 fullMismatch;
  logic [IdxWidth-1:0]  ptr;
  logic [IdxWidth-1:0]  ptr_d;
  logic                 ptrMismatch;
  logic [IdxWidth-1:0]  gnt;
  logic [IdxWidth-1:0]  scanPos;
  int                   scanIdx;
  logic                 found;
  logic                 accept;
  logic [2:0][1:0]      stateCopy_q;
  logic [1:0]           stateVote;
  state_e               state;
  logic                 stateMismatch;
  logic                 mismatch;
  logic [HoldWidth-1:0] holdCnt_q;
  logic [CntWidth-1:0]  faultCnt_q;
  logic [CntWidth-1:0]  faultCnt_d;
  logic                 threshHit;

  if (TmrStatus != 0) begin : gen_full_tmr
    assign fullVoted = (fifo_full_i[0] & fifo_full_i[1]) |
                       (fifo_full_i[0] & fifo_full_i[2]) |
                       (fifo_full_i[1] & fifo_full_i[2]);
    assign fullMismatch = (fifo_full_i != {HsWidth{fifo_full_i[0]}});
  end else begin : gen_full_single
    assign fullVoted    = fifo_full_i[0];
    assign fullMismatch = 1'b0;
  end

  // Each copy is refreshed from the voted value, so a single upset heals on the next edge.
  if (NumReq > 1) begin : gen_ptr
    logic [IdxWidth-1:0] ptr0_q, ptr1_q, ptr2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ptr0_q <= '0;
        ptr1_q <= '0;
        ptr2_q <= '0;
      end else begin
        ptr0_q <= ptr_d;
        ptr1_q <= ptr_d;
        ptr2_q <= ptr_d;
      end
    end

    assign ptr         = (ptr0_q & ptr1_q) | (ptr0_q & ptr2_q) | (ptr1_q & ptr2_q);
    assign ptrMismatch = !((ptr0_q == ptr1_q) && (ptr1_q == ptr2_q));
  end else begin : gen_ptr_const
    logic unusedPtr;
    assign unusedPtr   = ^ptr_d;
    assign ptr         = '0;
    assign ptrMismatch = 1'b0;
  end

  assign stateVote = (stateCopy_q[0] & stateCopy_q[1]) |
                     (stateCopy_q[0] & stateCopy_q[2]) |
                     (stateCopy_q[1] & stateCopy_q[2]);
  assign state         = state_e'(stateVote);
  assign stateMismatch = !((stateCopy_q[0] == stateCopy_q[1]) &&
                           (stateCopy_q[1] == stateCopy_q[2]));
  assign mismatch      = fullMismatch | ptrMismatch | stateMismatch;

  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    scanIdx = 0;
    scanPos = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      scanIdx = int'(ptr) + off;
      if (scanIdx >= int'(NumReq)) begin
        scanIdx = scanIdx - int'(NumReq);
      end
      scanPos = IdxWidth'(scanIdx);
      if (!found && req_valid_i[scanPos]) begin
        found = 1'b1;
        gnt   = scanPos;
      end
    end
  end

  // Reset gates the accept so handshake outputs hold their reset values even with valids high.
  assign accept = rst_ni && (state == StRun) && found && !fullVoted;

  always_comb begin
    fifo_data_o = '0;
    req_ready_o = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (gnt == IdxWidth'(i)) begin
        fifo_data_o    = req_data_i[i*DataWidth +: DataWidth];
        req_ready_o[i] = accept;
      end
    end
  end

  assign fifo_push_o  = {HsWidth{accept}};
  assign fifo_flush_o = {HsWidth{state == StFlush}};
  assign busy_o       = (state != StRun);

  always_comb begin
    ptr_d = ptr;
    if (state == StFlush) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = (gnt == IdxWidth'(NumReq - 1)) ? '0 : gnt + IdxWidth'(1);
    end
  end

  always_comb begin
    faultCnt_d = faultCnt_q;
    if ((state == StFlush) || !fifo_fault_i) begin
      faultCnt_d = '0;
    end else if (faultCnt_q != CntWidth'(FaultThresh)) begin
      faultCnt_d = faultCnt_q + CntWidth'(1);
    end
  end

  assign threshHit = (state == StRun) && (faultCnt_d == CntWidth'(FaultThresh));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateCopy_q <= {3{StRun}};
      holdCnt_q   <= '0;
      faultCnt_q  <= '0;
    end else begin
      faultCnt_q <= faultCnt_d;
      case (state)
        StRun: begin
          stateCopy_q <= (flush_req_i || threshHit) ? {3{StFlush}} : {3{StRun}};
        end
        StFlush: begin
          stateCopy_q <= {3{StHold}};
          holdCnt_q   <= HoldWidth'(HoldCycles - 1);
        end
        StHold: begin
          if (flush_req_i) begin
            stateCopy_q <= {3{StFlush}};
          end else if (holdCnt_q == '0) begin
            stateCopy_q <= {3{StRun}};
          end else begin
            stateCopy_q <= {3{StHold}};
            holdCnt_q   <= holdCnt_q - HoldWidth'(1);
          end
        end
        default: begin
          stateCopy_q <= {3{StRun}};
        end
      endcase
    end
  end

`ifdef REL_FIFO_ARB_STICKY_FAULT_EN
  logic faultSticky_q;

  // A new set event in the same cycle as a clear keeps the flag raised.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      faultSticky_q <= 1'b0;
    end else if (mismatch || threshHit) begin
      faultSticky_q <= 1'b1;
    end else if (fault_clear_i) begin
      faultSticky_q <= 1'b0;
    end
  end

  assign fault_o = faultSticky_q | mismatch;
`else
  logic unusedClear;
  assign unusedClear = fault_clear_i;
  assign fault_o     = mismatch;
`endif

endmodule

// File: tb/tb_rel_fifo_push_arbiter.sv
// Directed self-checking bench for rel_fifo_push_arbiter (NumReq=4, TMR status, FaultThresh=4, HoldCycles=2).
module tb_rel_fifo_push_arbiter;

  localparam int NumReq    = 4;
  localparam int DataWidth = 39;
  localparam int HsWidth   = 3;
`ifdef REL_FIFO_ARB_STICKY_FAULT_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  logic                        clk_i;
  logic                        rst_ni;
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq*DataWidth-1:0] req_data_i;
  logic [NumReq-1:0]           req_ready_o;
  logic                        flush_req_i;
  logic                        fault_clear_i;
  logic [HsWidth-1:0]          fifo_full_i;
  logic                        fifo_fault_i;
  logic [HsWidth-1:0]          fifo_push_o;
  logic [DataWidth-1:0]        fifo_data_o;
  logic [HsWidth-1:0]          fifo_flush_o;
  logic                        busy_o;
  logic                        fault_o;

  int checks = 0;
  int fails  = 0;

  rel_fifo_push_arbiter #(
    .NumReq     (NumReq),
    .DataWidth  (DataWidth),
    .TmrStatus  (1),
    .FaultThresh(4),
    .HoldCycles (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .flush_req_i  (flush_req_i),
    .fault_clear_i(fault_clear_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_fault_i (fifo_fault_i),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_flush_o (fifo_flush_o),
    .busy_o       (busy_o),
    .fault_o      (fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [DataWidth-1:0] slotData(input int i);
    return 39'h4A_1234_5600 + DataWidth'(i);
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic [3:0] valid, input logic [2:0] full,
                               input logic fault, input logic flushReq, input logic clear);
    @(posedge clk_i);
    #1;
    req_valid_i   = valid;
    fifo_full_i   = full;
    fifo_fault_i  = fault;
    flush_req_i   = flushReq;
    fault_clear_i = clear;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expReady, input logic expPush,
                             input logic expFlush, input logic expBusy, input logic expFault);
    checks++;
    assert (req_ready_o === expReady) else begin
      fails++;
      $error("[TB] FAIL %s ready: observed %b expected %b", tag, req_ready_o, expReady);
    end
    checks++;
    assert (fifo_push_o === {3{expPush}}) else begin
      fails++;
      $error("[TB] FAIL %s push: observed %b expected %b", tag, fifo_push_o, {3{expPush}});
    end
    checks++;
    assert (fifo_flush_o === {3{expFlush}}) else begin
      fails++;
      $error("[TB] FAIL %s flush: observed %b expected %b", tag, fifo_flush_o, {3{expFlush}});
    end
    checks++;
    assert (busy_o === expBusy) else begin
      fails++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy_o, expBusy);
    end
    checks++;
    assert (fault_o === expFault) else begin
      fails++;
      $error("[TB] FAIL %s fault: observed %b expected %b", tag, fault_o, expFault);
    end
  endtask

  task automatic checkData(input string tag, input int expGnt);
    checks++;
    assert (fifo_data_o === slotData(expGnt)) else begin
      fails++;
      $error("[TB] FAIL %s data: observed %h expected %h", tag, fifo_data_o, slotData(expGnt));
    end
  endtask

  task automatic checkPtrCopies(input string tag, input logic [1:0] expPtr);
    checks++;
    assert ((dut.gen_ptr.ptr0_q === expPtr) && (dut.gen_ptr.ptr1_q === expPtr) &&
            (dut.gen_ptr.ptr2_q === expPtr)) else begin
      fails++;
      $error("[TB] FAIL %s ptr copies: observed %0d/%0d/%0d expected %0d", tag,
             dut.gen_ptr.ptr0_q, dut.gen_ptr.ptr1_q, dut.gen_ptr.ptr2_q, expPtr);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_ni        = 1'b0;
    req_valid_i   = 4'hF;
    fifo_full_i   = 3'b000;
    fifo_fault_i  = 1'b0;
    flush_req_i   = 1'b0;
    fault_clear_i = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      req_data_i[i*DataWidth +: DataWidth] = slotData(i);
    end

    // Reset with every requester valid: handshake stays quiet.
    repeat (2) @(posedge clk_i);
    #2;
    checkOutput("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkPtrCopies("reset", 2'd0);
    req_valid_i = 4'h0;
    #3;
    rst_ni = 1'b1;

    // Round robin with all valid.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rr%0d", c), 4'(1 << (c % 4)), 1'b1, 1'b0, 1'b0, 1'b0);
      checkData($sformatf("rr%0d", c), c % 4);
    end

    // Skip and wrap.
    applyStimulus(4'b0010, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("skip1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    checkData("wrap", 0);
    applyStimulus(4'b0010, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("afterwrap", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure holds the pointer at 2.
    applyStimulus(4'hF, 3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("full1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'hF, 3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("full2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("unfull", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    checkData("unfull", 2);

    // Full copies disagree: majority wins, fault flagged.
    applyStimulus(4'hF, 3'b001, 1'b0, 1'b0, 1'b0);
    checkOutput("fullvote0", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 3'b110, 1'b0, 1'b0, 1'b0);
    checkOutput("fullvote1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear1", 4'b0000, 1'b0, 1'b0, 1'b0, Sticky);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("cleared1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Four fault cycles trigger a flush; pointer moves to 2 first, flush returns it to 0.
    applyStimulus(4'b0010, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("fault1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("fault2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("fault3", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("fault4", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("flush", 4'b0000, 1'b0, 1'b1, 1'b1, Sticky);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold1", 4'b0000, 1'b0, 1'b0, 1'b1, Sticky);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold2", 4'b0000, 1'b0, 1'b0, 1'b1, Sticky);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("resume", 4'b0001, 1'b1, 1'b0, 1'b0, Sticky);
    checkData("resume", 0);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear2", 4'b0000, 1'b0, 1'b0, 1'b0, Sticky);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("cleared2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // A three-cycle burst stays below threshold.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'h0, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("burst%0d", c), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("burstend0", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("burstend1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Software flush, then reset while in HOLD.
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("swflushreq", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("swflush", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("swhold", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("rsthold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    req_valid_i = 4'h0;
    #2;
    rst_ni = 1'b1;
    applyStimulus(4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("postrst", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Upset one pointer copy (voted ptr is 1): grant unaffected, copies heal to 2.
    @(posedge clk_i);
    #1;
    force dut.gen_ptr.ptr1_q = 2'd3;
    req_valid_i = 4'b1110;
    #1;
    checkOutput("tmrptr", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
    checkData("tmrptr", 1);
    #2;
    release dut.gen_ptr.ptr1_q;
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkPtrCopies("tmrheal", 2'd2);
    checkOutput("tmrheal", 4'b0000, 1'b0, 1'b0, 1'b0, Sticky);
    applyStimulus(4'h0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear3", 4'b0000, 1'b0, 1'b0, 1'b0, Sticky);
    applyStimulus(4'b1000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("final", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkData("final", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
